// File: rtl/hc595_pkg.sv
// Shared constants for the 74HC595 display-link receiver: frame width, segment bit
// positions, the hex glyph table and the glyph decoder.
package hc595_pkg;

   localparam int unsigned SR_WIDTH_DEF = 16;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   localparam logic [7:0] BLANK_PAT = 8'hFF;

   // Active-low glyphs with dp off; entry i is the pattern for hex digit i.
   localparam logic [15:0][7:0] GLYPH_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef struct packed {
      logic       known;
      logic [3:0] hex;
   } glyph_t;

   // Input is an active-low pattern; the decimal point is ignored.
   function automatic glyph_t glyph_decode(input logic [7:0] pat_al);
      logic [7:0] p;
      glyph_t     g;
      p         = pat_al;
      p[SEG_DP] = 1'b1;
      g         = '0;
      for (int i = 0; i < 16; i++) begin
         if (p == GLYPH_TABLE[i]) begin
            g.known = 1'b1;
            g.hex   = 4'(i);
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/hc595_pin_sync.sv
// Multi-flop synchroniser with a registered rising-edge pulse. level_o is delayed to stay
// aligned with rise_o, so a data pin synchronised with the same depth lines up with its clock.
module hc595_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/hc595_frame_receiver.sv
// Receiver for the data_ser/srclk/rclk 595 link: deserialises frames, checks their length,
// keeps an 8-digit segment image and decodes it to hex nibbles.
module hc595_frame_receiver
   import hc595_pkg::*;
#(
   parameter int unsigned SR_WIDTH       = SR_WIDTH_DEF,
   parameter int unsigned DIGITS         = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  data_ser,
   input  logic                  srclk,
   input  logic                  rclk,
   output logic [7:0]            seg_pat,
   output logic [7:0]            dig_sel,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic                  sel_err,
   output logic [8*DIGITS-1:0]   disp_buf,
   output logic [4*DIGITS-1:0]   disp_hex,
   output logic [DIGITS-1:0]     disp_known
);

   localparam int unsigned   CntW       = $clog2(SR_WIDTH + 2);
   localparam logic [CntW-1:0] CntFull  = CntW'(SR_WIDTH);
   localparam logic [CntW-1:0] CntSat   = CntW'(SR_WIDTH + 1);
   localparam logic [7:0]    BlankDigit = SEG_ACTIVE_LOW ? BLANK_PAT : ~BLANK_PAT;

   logic data_sync, srclk_rise, rclk_rise;
   logic unused_data_rise, unused_srclk_lvl, unused_rclk_lvl;

   hc595_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .clk_i(sys_clk), .rst_i(sys_rst), .pin_i(data_ser),
      .level_o(data_sync), .rise_o(unused_data_rise)
   );
   hc595_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_srclk (
      .clk_i(sys_clk), .rst_i(sys_rst), .pin_i(srclk),
      .level_o(unused_srclk_lvl), .rise_o(srclk_rise)
   );
   hc595_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
      .clk_i(sys_clk), .rst_i(sys_rst), .pin_i(rclk),
      .level_o(unused_rclk_lvl), .rise_o(rclk_rise)
   );

   logic [SR_WIDTH-1:0]          shreg_q, shreg_d;
   logic [CntW-1:0]              cnt_q, cnt_d;
   logic [7:0]                   seg_q, seg_d, dig_q, dig_d;
   logic                         fv_q, fv_d, fe_q, fe_d, se_q, se_d;
   logic [DIGITS-1:0][7:0]       buf_q, buf_d;
   logic [7:0]                   sel_n;

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      seg_d   = seg_q;
      dig_d   = dig_q;
      fv_d    = 1'b0;
      fe_d    = 1'b0;
      // Latch sees pre-shift state when both clocks rise together, like tied 595 clocks.
      if (rclk_rise) begin
         seg_d = shreg_q[SR_WIDTH-1 -: 8];
         dig_d = shreg_q[7:0];
         fv_d  = (cnt_q == CntFull);
         fe_d  = (cnt_q != CntFull);
         cnt_d = '0;
      end
      if (srclk_rise) begin
         shreg_d = {shreg_q[SR_WIDTH-2:0], data_sync};
         if (rclk_rise)            cnt_d = CntW'(1);
         else if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
      end
   end

   assign sel_n = dig_q ^ {8{DIG_ACTIVE_LOW}};

   always_comb begin
      buf_d = buf_q;
      se_d  = 1'b0;
      if (fv_q) begin
         if ($onehot(sel_n)) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (sel_n[i]) buf_d[i] = seg_q;
            end
         end else begin
            se_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         seg_q   <= '0;
         dig_q   <= '0;
         fv_q    <= 1'b0;
         fe_q    <= 1'b0;
         se_q    <= 1'b0;
         buf_q   <= {DIGITS{BlankDigit}};
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         fv_q    <= fv_d;
         fe_q    <= fe_d;
         se_q    <= se_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      disp_hex   = '0;
      disp_known = '0;
      for (int i = 0; i < DIGITS; i++) begin
         glyph_t g;
         g = glyph_decode(SEG_ACTIVE_LOW ? buf_q[i] : ~buf_q[i]);
         disp_hex[4*i +: 4] = g.hex;
         disp_known[i]      = g.known;
      end
   end

   assign seg_pat     = seg_q;
   assign dig_sel     = dig_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign sel_err     = se_q;
   assign disp_buf    = buf_q;

endmodule

// File: tb/tb_hc595_frame_receiver.sv
// Directed bench for hc595_frame_receiver: drives the three-wire link slowly enough to meet
// the oversampling timing and checks latched outputs, pulses and the decoded display image.
module tb_hc595_frame_receiver;

   logic        sys_clk = 1'b0;
   logic        sys_rst, data_ser, srclk, rclk;
   logic [7:0]  seg_pat, dig_sel;
   logic        frame_valid, frame_err, sel_err;
   logic [63:0] disp_buf;
   logic [31:0] disp_hex;
   logic [7:0]  disp_known;

   int checks   = 0;
   int failures = 0;
   int cyc = 0, fv_cnt = 0, fe_cnt = 0, se_cnt = 0, fv_cyc = 0, se_cyc = 0;
   int lat;

   hc595_frame_receiver dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .data_ser(data_ser), .srclk(srclk), .rclk(rclk),
      .seg_pat(seg_pat), .dig_sel(dig_sel), .frame_valid(frame_valid),
      .frame_err(frame_err), .sel_err(sel_err), .disp_buf(disp_buf),
      .disp_hex(disp_hex), .disp_known(disp_known)
   );

   always #10 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      cyc <= cyc + 1;
      if (!sys_rst) begin
         if (frame_valid) begin fv_cnt <= fv_cnt + 1; fv_cyc <= cyc; end
         if (frame_err)   fe_cnt <= fe_cnt + 1;
         if (sel_err)     begin se_cnt <= se_cnt + 1; se_cyc <= cyc; end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         data_ser = val[i];
         wait_cycles(3);
         srclk = 1'b1;
         wait_cycles(3);
         srclk = 1'b0;
         wait_cycles(1);
      end
   endtask

   // Raises rclk (and srclk too if with_shift), measures cycles to the first pulse.
   task automatic latch_pulse(input bit with_shift);
      int k;
      bit seen;
      @(posedge sys_clk); #1;
      rclk = 1'b1;
      if (with_shift) srclk = 1'b1;
      k = 0;
      seen = 1'b0;
      while (!seen && k < 12) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         k++;
         if (frame_valid || frame_err) seen = 1'b1;
      end
      lat = k;
      if (!seen) begin
         failures++;
         $display("FAIL latch_timeout got=no pulse within %0d cycles required=pulse", k);
      end
      wait_cycles(1);
      rclk  = 1'b0;
      srclk = 1'b0;
      wait_cycles(5);
   endtask

   task automatic test_reset;
      sys_rst = 1'b1; data_ser = 1'b0; srclk = 1'b0; rclk = 1'b0;
      wait_cycles(3);
      checks++;
      if ({seg_pat, dig_sel, frame_valid, frame_err, sel_err} !== 19'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0",
                  {seg_pat, dig_sel, frame_valid, frame_err, sel_err});
      end
      checks++;
      if (disp_buf !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failures++; $display("FAIL reset_disp_buf got=%h required=all FF", disp_buf);
      end
      checks++;
      if (disp_hex !== 32'h0 || disp_known !== 8'h0) begin
         failures++;
         $display("FAIL reset_decode got=%h/%h required=0/0", disp_hex, disp_known);
      end
      sys_rst = 1'b0;
      wait_cycles(3);
   endtask

   task automatic test_single_frame;
      int fv0 = fv_cnt, fe0 = fe_cnt;
      send_bits(32'hF904, 16);
      latch_pulse(1'b0);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL latch_latency got=%0d required=4", lat); end
      checks++;
      if (seg_pat !== 8'hF9 || dig_sel !== 8'h04) begin
         failures++; $display("FAIL single_latch got=%h_%h required=F9_04", seg_pat, dig_sel);
      end
      checks++;
      if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0) begin
         failures++;
         $display("FAIL single_pulses got=fv%0d fe%0d required=fv1 fe0", fv_cnt - fv0, fe_cnt - fe0);
      end
      checks++;
      if (disp_buf[23:16] !== 8'hF9 || disp_hex[11:8] !== 4'h1 || disp_known !== 8'h04) begin
         failures++;
         $display("FAIL single_digit2 got=%h/%h/%h required=F9/1/04",
                  disp_buf[23:16], disp_hex[11:8], disp_known);
      end
   endtask

   task automatic test_all_digits;
      logic [15:0] frames [8] = '{16'hC001, 16'hF902, 16'hA404, 16'hB008,
                                  16'h9910, 16'h9220, 16'h8240, 16'hF880};
      for (int i = 0; i < 8; i++) begin
         send_bits({16'h0, frames[i]}, 16);
         latch_pulse(1'b0);
      end
      checks++;
      if (disp_hex !== 32'h7654_3210 || disp_known !== 8'hFF) begin
         failures++;
         $display("FAIL all_digits_decode got=%h/%h required=76543210/FF", disp_hex, disp_known);
      end
      checks++;
      if (disp_buf !== 64'hF882_9299_B0A4_F9C0) begin
         failures++; $display("FAIL all_digits_buf got=%h required=F8829299B0A4F9C0", disp_buf);
      end
   endtask

   task automatic test_bad_length;
      int fv0 = fv_cnt, fe0 = fe_cnt;
      send_bits(32'h0000_1234, 15);
      latch_pulse(1'b0);
      checks++;
      if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
         failures++;
         $display("FAIL short_frame got=fe%0d fv%0d required=fe1 fv0", fe_cnt - fe0, fv_cnt - fv0);
      end
      checks++;
      if (disp_buf !== 64'hF882_9299_B0A4_F9C0) begin
         failures++; $display("FAIL short_no_write got=%h required=F8829299B0A4F9C0", disp_buf);
      end
      fe0 = fe_cnt; fv0 = fv_cnt;
      send_bits(32'h0001_A401, 17);
      latch_pulse(1'b0);
      checks++;
      if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
         failures++;
         $display("FAIL long_frame got=fe%0d fv%0d required=fe1 fv0", fe_cnt - fe0, fv_cnt - fv0);
      end
      checks++;
      if (seg_pat !== 8'hA4 || dig_sel !== 8'h01) begin
         failures++; $display("FAIL long_latch got=%h_%h required=A4_01", seg_pat, dig_sel);
      end
      checks++;
      if (disp_buf !== 64'hF882_9299_B0A4_F9C0) begin
         failures++; $display("FAIL long_no_write got=%h required=F8829299B0A4F9C0", disp_buf);
      end
   endtask

   task automatic test_select;
      int fv0 = fv_cnt, se0 = se_cnt;
      send_bits(32'h8605, 16);
      latch_pulse(1'b0);
      checks++;
      if (fv_cnt - fv0 !== 1 || se_cnt - se0 !== 1) begin
         failures++;
         $display("FAIL sel_err_pulse got=fv%0d se%0d required=fv1 se1", fv_cnt - fv0, se_cnt - se0);
      end
      checks++;
      if (se_cyc - fv_cyc !== 1) begin
         failures++; $display("FAIL sel_err_timing got=%0d required=1", se_cyc - fv_cyc);
      end
      checks++;
      if (disp_buf !== 64'hF882_9299_B0A4_F9C0) begin
         failures++; $display("FAIL sel_no_write got=%h required=F8829299B0A4F9C0", disp_buf);
      end
      send_bits(32'h7F01, 16);
      latch_pulse(1'b0);
      checks++;
      if (disp_buf[7:0] !== 8'h7F || disp_known !== 8'hFE || disp_hex[3:0] !== 4'h0) begin
         failures++;
         $display("FAIL dp_only got=%h/%h/%h required=7F/FE/0",
                  disp_buf[7:0], disp_known, disp_hex[3:0]);
      end
   endtask

   task automatic test_simultaneous;
      int fv0 = fv_cnt;
      send_bits(32'h8001, 16);
      data_ser = 1'b1;
      wait_cycles(3);
      latch_pulse(1'b1);
      checks++;
      if (fv_cnt - fv0 !== 1 || seg_pat !== 8'h80 || dig_sel !== 8'h01) begin
         failures++;
         $display("FAIL simul_latch got=fv%0d %h_%h required=fv1 80_01",
                  fv_cnt - fv0, seg_pat, dig_sel);
      end
      checks++;
      if (disp_hex[3:0] !== 4'h8 || disp_known[0] !== 1'b1) begin
         failures++; $display("FAIL simul_decode got=%h required=8", disp_hex[3:0]);
      end
      // The simultaneous shift counts as bit 1 of the next frame.
      fv0 = fv_cnt;
      send_bits(32'h7901, 15);
      latch_pulse(1'b0);
      checks++;
      if (fv_cnt - fv0 !== 1 || seg_pat !== 8'hF9 || dig_sel !== 8'h01) begin
         failures++;
         $display("FAIL simul_count got=fv%0d %h_%h required=fv1 F9_01",
                  fv_cnt - fv0, seg_pat, dig_sel);
      end
   endtask

   task automatic test_reset_mid_frame;
      int fv0, fe0;
      send_bits(32'h01AB, 9);
      sys_rst = 1'b1;
      wait_cycles(2);
      checks++;
      if ({seg_pat, dig_sel, frame_valid, frame_err, sel_err} !== 19'h0 ||
          disp_buf !== 64'hFFFF_FFFF_FFFF_FFFF || disp_hex !== 32'h0 || disp_known !== 8'h0) begin
         failures++;
         $display("FAIL mid_reset_values got=%h_%h %h %h %h required=00_00 all FF 0 0",
                  seg_pat, dig_sel, disp_buf, disp_hex, disp_known);
      end
      sys_rst = 1'b0;
      wait_cycles(3);
      fv0 = fv_cnt; fe0 = fe_cnt;
      send_bits(32'h8801, 16);
      latch_pulse(1'b0);
      checks++;
      if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0) begin
         failures++;
         $display("FAIL mid_reset_frame got=fv%0d fe%0d required=fv1 fe0", fv_cnt - fv0, fe_cnt - fe0);
      end
      checks++;
      if (disp_hex !== 32'h0000_000A || disp_known !== 8'h01) begin
         failures++;
         $display("FAIL mid_reset_decode got=%h/%h required=0000000A/01", disp_hex, disp_known);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_all_digits();
      test_bad_length();
      test_select();
      test_simultaneous();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
